// File: rtl/alu_result_streamer.sv
// Captures a 5x5 signed-byte ALU result and streams its active NxN sub-matrix one element per beat.
// Optional overflow/size header beat ahead of the elements: define STREAM_OVF_HEADER_EN.
module alu_result_streamer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [199:0] C_flat,
  input  logic         overflow_in,
  input  logic [2:0]   size,
  output logic         busy,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   out_row,
  output logic [2:0]   out_col,
  output logic         out_last,
  output logic         overflow_flag,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     row_q, row_d;
  logic [2:0]     col_q, col_d;
  logic [2:0]     n_q, n_d;
  logic           ovf_q, ovf_d;
  logic [199:0]   mat_q, mat_d;
  logic signed [7:0] elem;
  logic           last_elem;

  // Orders outside 2..5 fall back to the full 5x5 matrix.
  function automatic logic [2:0] eff_size(input logic [2:0] s);
    return (s >= 3'd2 && s <= 3'd5) ? s : 3'd5;
  endfunction

  // Linear 5x5 position row*5+col, independent of the active order.
  function automatic logic [4:0] elem_idx(input logic [2:0] r, input logic [2:0] c);
    return {r, 2'b00} + {2'b00, r} + {2'b00, c};
  endfunction

  assign elem      = mat_q[{elem_idx(row_q, col_q), 3'b000} +: 8];
  assign last_elem = (row_q == n_q - 3'd1) && (col_q == n_q - 3'd1);
  assign overflow_flag = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      n_q     <= 3'd5;
      ovf_q   <= 1'b0;
      mat_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
      mat_q   <= mat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    n_d       = n_q;
    ovf_d     = ovf_q;
    mat_d     = mat_q;
    busy      = (state_q != S_IDLE);
    out_valid = 1'b0;
    out_data  = 8'd0;
    out_row   = 3'd0;
    out_col   = 3'd0;
    out_last  = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          mat_d = C_flat;
          ovf_d = overflow_in;
          n_d   = eff_size(size);
          row_d = 3'd0;
          col_d = 3'd0;
`ifdef STREAM_OVF_HEADER_EN
          state_d = S_HEADER;
`else
          state_d = S_STREAM;
`endif
        end
      end
`ifdef STREAM_OVF_HEADER_EN
      S_HEADER: begin
        out_valid = 1'b1;
        out_data  = {ovf_q, 4'b0000, n_q};
        out_row   = 3'd7;
        out_col   = 3'd7;
        if (out_ready) state_d = S_STREAM;
      end
`endif
      S_STREAM: begin
        out_valid = 1'b1;
        out_data  = elem;
        out_row   = row_q;
        out_col   = col_q;
        out_last  = last_elem;
        // Indices advance only on a handshake, so a stalled beat stays put.
        if (out_ready) begin
          if (last_elem) begin
            state_d = S_DONE;
          end else if (col_q == n_q - 3'd1) begin
            col_d = 3'd0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_result_streamer.sv
// Table-driven bench for alu_result_streamer with a beat scoreboard fed from a matrix model.
module tb_alu_result_streamer;

`ifdef STREAM_OVF_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, load, overflow_in, out_ready;
  logic [199:0] C_flat;
  logic [2:0]   size;
  logic         busy, out_valid, out_last, overflow_flag, done;
  logic [7:0]   out_data;
  logic [2:0]   out_row, out_col;

  alu_result_streamer dut (
    .clk(clk), .rst_n(rst_n), .load(load), .C_flat(C_flat),
    .overflow_in(overflow_in), .size(size), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .overflow_flag(overflow_flag), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] r;
    logic [2:0] c;
    logic       l;
  } beat_t;

  typedef struct {
    logic [2:0] sz;
    bit         ovf;
    int         sel;
    int         rmode;
    int         beats;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[7];
  int    checks = 0;
  int    failures = 0;
  int    hs_cnt = 0;
  bit    done_seen = 0, exp_done = 0, stall_prev = 0, mon_en = 0;
  logic [15:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] gen(input int sel, input int i);
    int v;
    v = (sel == 0) ? i : (i * 11 - 100);
    return v[7:0];
  endfunction

  // Scoreboard: pops one expected beat per observed handshake.
  always begin
    @(negedge clk);
    #1;
    if (mon_en && rst_n) begin
      if (stall_prev)
        chk("stall_hold", {16'd0, out_valid, out_data, out_row, out_col, out_last},
            {16'd0, held});
      if (exp_done) begin
        chk("done_pulse", {30'd0, done, out_valid}, 32'b10);
        done_seen = 1;
        exp_done  = 0;
      end else if (done) begin
        chk("early_done", {31'd0, done}, 32'd0);
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat actual=%0h expected=none", out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat", {17'd0, out_data, out_row, out_col, out_last},
              {17'd0, e.d, e.r, e.c, e.l});
          if (exp_q.size() == 0) exp_done = 1;
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_valid, out_data, out_row, out_col, out_last};
    end
  end

  task automatic run_stream(input logic [2:0] sz, input bit ovf, input int sel,
                            input int rmode, input bit disturb, input int abort_at,
                            input int exp_beats);
    int n;
    logic [199:0] m;
    bit aborted;
    n = (sz >= 3'd2 && sz <= 3'd5) ? int'(sz) : 5;
    for (int i = 0; i < 25; i++) m[i*8 +: 8] = gen(sel, i);
    exp_q.delete();
    hs_cnt = 0; done_seen = 0; exp_done = 0; stall_prev = 0; aborted = 0;
`ifdef STREAM_OVF_HEADER_EN
    exp_q.push_back('{{ovf, 4'b0000, 3'(n)}, 3'd7, 3'd7, 1'b0});
`endif
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        exp_q.push_back('{m[(r*5+c)*8 +: 8], 3'(r), 3'(c), (r == n-1) && (c == n-1)});

    @(negedge clk);
    load = 1'b1; size = sz; C_flat = m; overflow_in = ovf; out_ready = 1'b0;
    mon_en = 1;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(negedge clk);
      if (abort_at > 0 && hs_cnt >= abort_at) begin
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        chk("abort_hs", hs_cnt, abort_at);
        chk("abort_out", {14'd0, busy, out_valid, out_data, out_row, out_col, out_last,
            overflow_flag, done}, 32'd0);
        aborted = 1;
        break;
      end
      load        = (disturb && cyc == 3);
      C_flat      = (disturb && cyc == 3) ? {7{$urandom}} : ~m;
      size        = (disturb && cyc == 3) ? 3'd2 : sz;
      overflow_in = ~ovf;
      out_ready   = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      #2;
      if (cyc == 0) chk("first_beat_busy_valid", {30'd0, busy, out_valid}, 32'b11);
    end
    if (!aborted) begin
      chk("done_seen", {31'd0, done_seen}, 32'd1);
      chk("beat_count", hs_cnt, exp_beats);
      chk("queue_empty", exp_q.size(), 0);
      chk("overflow_flag", {31'd0, overflow_flag}, {31'd0, ovf});
      @(negedge clk);
      #1;
      chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    end
    mon_en = 0;
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; out_ready = 1'b0; C_flat = '0; size = 3'd0;
    overflow_in = 1'b0;
    vecs[0] = '{3'd5, 1'b0, 0, 0, 25 + HDR};
    vecs[1] = '{3'd3, 1'b1, 0, 0, 9 + HDR};
    vecs[2] = '{3'd0, 1'b0, 0, 0, 25 + HDR};
    vecs[3] = '{3'd2, 1'b0, 0, 1, 4 + HDR};
    vecs[4] = '{3'd4, 1'b1, 1, 1, 16 + HDR};
    vecs[5] = '{3'd7, 1'b0, 1, 0, 25 + HDR};
    vecs[6] = '{3'd2, 1'b1, 1, 0, 4 + HDR};

    #1;
    chk("reset_state", {14'd0, busy, out_valid, out_data, out_row, out_col, out_last,
        overflow_flag, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k])
      run_stream(vecs[k].sz, vecs[k].ovf, vecs[k].sel, vecs[k].rmode, 1'b0, 0, vecs[k].beats);

    // Load and new C_flat mid-stream must not disturb the captured matrix.
    run_stream(3'd5, 1'b0, 0, 0, 1'b1, 0, 25 + HDR);

    // Asynchronous abort after the 7th handshake, then a clean restart.
    run_stream(3'd5, 1'b1, 0, 0, 1'b0, 7, 25 + HDR);
    @(negedge clk);
    #1;
    chk("held_in_reset", {30'd0, busy, out_valid}, 32'd0);
    rst_n = 1'b1;
    run_stream(3'd3, 1'b0, 1, 0, 1'b0, 0, 9 + HDR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_streamer.md
# alu_result_streamer

Sequential read-out stage for the matrix ALU: captures one 5x5 result matrix (200-bit flattened, 8-bit signed elements, row-major, element (i,j) at bits [(i*5+j)*8 +: 8]) plus its overflow flag, then emits the active NxN sub-matrix one element per beat over a valid/ready byte stream. It sits between the combinational ALU result bus and the coprocessor's host-side output path, and frees the ALU bus after a single capture cycle.

## Interface
- No parameters; geometry is fixed at 5x5 x 8-bit.
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- load  input  1  capture request; sampled only in IDLE
- C_flat  input  200  flattened result matrix from ALU
- overflow_in  input  1  ALU overflow flag accompanying C_flat
- size  input  3  active matrix order N, sampled with load; 2..5 valid, 0/1/6/7 treated as 5
- busy  output  1  high in every state except IDLE
- out_data  output  8  current stream byte
- out_valid  output  1  out_data/out_row/out_col/out_last valid
- out_ready  input  1  downstream accepts beat when high with out_valid
- out_row  output  3  row index of current element
- out_col  output  3  column index of current element
- out_last  output  1  high on final element beat only
- overflow_flag  output  1  registered copy of captured overflow_in
- done  output  1  one-cycle pulse after final handshake

## Operation
- States: IDLE, HEADER (only with macro), STREAM, DONE.
- IDLE: load=1 -> register C_flat, overflow_in, effective size N; row=col=0; go to HEADER if macro enabled, else STREAM. load=0 -> stay.
- load while busy is ignored; captured data unaffected.
- STREAM: out_valid=1; out_data = captured element (row,col); handshake = out_valid & out_ready.
- On handshake: col+1; if col==N-1 then col=0, row+1. Handshake with row==N-1 and col==N-1 -> DONE.
- out_last = STREAM & row==N-1 & col==N-1.
- No handshake -> all out_* held stable (no change while valid & !ready).
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE.
- Elements outside NxN are never emitted; indices always refer to 5x5 positions (row*5+col).
- overflow_flag updates only on capture; holds until next capture or reset.

## Timing
- Reset values: state IDLE, busy 0, out_valid 0, out_data 0, out_row 0, out_col 0, out_last 0, overflow_flag 0, done 0; captured matrix cleared.
- load high at edge k -> busy and out_valid high from cycle k+1 (first beat visible one cycle after capture).
- Throughput: one beat per cycle while out_ready held high; no bubbles between beats.
- Latency, ready always high, no header: N*N beat cycles, done pulses in the cycle after the last handshake, busy falls the cycle after done; load accepted again in that IDLE cycle.
- rst_n low mid-stream: immediate abort, outputs to reset values asynchronously, stream not resumed.
- C_flat changes after capture have no effect on the stream.

## Configuration
- Macro STREAM_OVF_HEADER_EN.
- Defined: HEADER state precedes STREAM; one beat with out_data = {overflow_flag, 4'b0000, N[2:0]}, out_row=out_col=3'd7, out_last=0; advance to STREAM on its handshake. Total beats N*N+1.
- Undefined: HEADER state absent; capture goes straight to STREAM; total beats N*N; overflow visible only on overflow_flag.

## Test plan
- size=5, C_flat elements = index 0..24, out_ready=1 -> 25 beats, data 0..24 in order, out_last on data 24 (row 4, col 4), done one cycle later.
- size=3, same matrix -> 9 beats: 0,1,2,5,6,7,10,11,12; out_last on 12; size=0 -> behaves as size 5.
- out_ready toggling 1,0,0,1... during size=2 stream -> data/indices held while stalled, exactly 4 handshakes, sequence 0,1,5,6.
- load re-asserted and C_flat changed mid-stream -> ignored, original data streamed to completion.
- rst_n pulsed low after 7th handshake -> all outputs 0 immediately, busy 0; subsequent load restarts from (0,0).
- With STREAM_OVF_HEADER_EN, overflow_in=1, size=4 -> first beat 8'h84 at row/col 7, then 16 elements, overflow_flag=1.
